// File: rtl/sp_ram_param.sv
`default_nettype none
// ============================================================================
// Module      : sp_ram_param
// Description : Parametrised single-port synchronous RAM with byte-lane write
//               enables, selectable read-during-write mode and post-reset clear.
// Revision    : 1.0 - initial release
// ============================================================================
module sp_ram_param #(
    parameter int DATA_W       = 16,
    parameter int BYTE_W       = 8,
    parameter int ADDR_W       = 8,
    parameter int DEPTH        = 256,
    parameter int RW_MODE      = 0,
    parameter int CLEAR_ON_RST = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ce,
    input  logic                       we,
    input  logic [DATA_W/BYTE_W-1:0]   be,
    input  logic [ADDR_W-1:0]          addr,
    input  logic [DATA_W-1:0]          din,
    output logic [DATA_W-1:0]          dout,
    output logic                       rd_valid,
    output logic                       busy,
    output logic                       err
);

    localparam int                c_nb    = DATA_W / BYTE_W;
    localparam logic [ADDR_W:0]   c_depth = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] c_last  = ADDR_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_IDLE  = 1'b1
    } state_t;

    localparam state_t c_init_state = (CLEAR_ON_RST != 0) ? S_CLEAR : S_IDLE;
    localparam logic   c_init_busy  = (CLEAR_ON_RST != 0);

    state_t             r_state;
    logic [ADDR_W-1:0]  r_clr_ptr;
    logic               r_busy;
    logic [DATA_W-1:0]  r_dout;
    logic               r_rd_valid;
    logic               r_err;
    logic [DATA_W-1:0]  r_mem [DEPTH];

    logic               w_addr_ok;
    logic               w_accept;
    logic               w_reject;
    logic [DATA_W-1:0]  w_rd_word;
    logic [DATA_W-1:0]  w_merged;

    assign w_addr_ok = ({1'b0, addr} < c_depth);
    assign w_accept  = ce & ~r_busy & w_addr_ok;
    assign w_reject  = ce & (r_busy | ~w_addr_ok);
    assign w_rd_word = r_mem[addr];

    // Lanes with be cleared keep the stored byte, giving the post-merge word.
    generate
        for (genvar i = 0; i < c_nb; i++) begin : g_lane
            assign w_merged[i*BYTE_W +: BYTE_W] = be[i] ? din[i*BYTE_W +: BYTE_W]
                                                        : w_rd_word[i*BYTE_W +: BYTE_W];
        end
    endgenerate

    // Clear path and user path are mutually exclusive through r_busy.
    always_ff @(posedge clk) begin
        if (r_busy) begin
            r_mem[r_clr_ptr] <= '0;
        end else if (w_accept && we) begin
            r_mem[addr] <= w_merged;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_init_state;
            r_clr_ptr  <= '0;
            r_busy     <= c_init_busy;
            r_dout     <= '0;
            r_rd_valid <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_rd_valid <= 1'b0;
            r_err      <= w_reject;
            case (r_state)
                S_CLEAR: begin
                    r_clr_ptr <= r_clr_ptr + 1'b1;
                    if (r_clr_ptr == c_last) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    if (w_accept) begin
                        if (!we) begin
                            r_dout     <= w_rd_word;
                            r_rd_valid <= 1'b1;
                        end else if (RW_MODE == 0) begin
                            r_dout     <= w_rd_word;
                            r_rd_valid <= 1'b1;
                        end else if (RW_MODE == 1) begin
                            r_dout     <= w_merged;
                            r_rd_valid <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign dout     = r_dout;
    assign rd_valid = r_rd_valid;
    assign busy     = r_busy;
    assign err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sp_ram_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_sp_ram_param
// Description : Self-checking bench for sp_ram_param; four instances covering
//               the three read-during-write modes and a reduced depth.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sp_ram_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce, we;
    logic [1:0]  be;
    logic [7:0]  addr;
    logic [15:0] din;

    logic [15:0] dout_a [4];
    logic        rv_a   [4];
    logic        err_a  [4];
    logic        busy_a [4];

    int total = 0;
    int bad   = 0;

    int          c_depth [4] = '{256, 256, 256, 200};
    int          c_mode  [4] = '{0, 1, 2, 0};
    logic [15:0] m_mem   [4][256];
    logic [15:0] m_dout  [4];
    logic        m_rv    [4];
    logic        m_err   [4];
    int          m_edges;

    always #5 clk = ~clk;

    sp_ram_param #(.DATA_W(16), .BYTE_W(8), .ADDR_W(8), .DEPTH(256), .RW_MODE(0), .CLEAR_ON_RST(1)) u_m0 (
        .clk(clk), .rst(rst), .ce(ce), .we(we), .be(be), .addr(addr), .din(din),
        .dout(dout_a[0]), .rd_valid(rv_a[0]), .busy(busy_a[0]), .err(err_a[0]));
    sp_ram_param #(.DATA_W(16), .BYTE_W(8), .ADDR_W(8), .DEPTH(256), .RW_MODE(1), .CLEAR_ON_RST(1)) u_m1 (
        .clk(clk), .rst(rst), .ce(ce), .we(we), .be(be), .addr(addr), .din(din),
        .dout(dout_a[1]), .rd_valid(rv_a[1]), .busy(busy_a[1]), .err(err_a[1]));
    sp_ram_param #(.DATA_W(16), .BYTE_W(8), .ADDR_W(8), .DEPTH(256), .RW_MODE(2), .CLEAR_ON_RST(1)) u_m2 (
        .clk(clk), .rst(rst), .ce(ce), .we(we), .be(be), .addr(addr), .din(din),
        .dout(dout_a[2]), .rd_valid(rv_a[2]), .busy(busy_a[2]), .err(err_a[2]));
    sp_ram_param #(.DATA_W(16), .BYTE_W(8), .ADDR_W(8), .DEPTH(200), .RW_MODE(0), .CLEAR_ON_RST(1)) u_d200 (
        .clk(clk), .rst(rst), .ce(ce), .we(we), .be(be), .addr(addr), .din(din),
        .dout(dout_a[3]), .rd_valid(rv_a[3]), .busy(busy_a[3]), .err(err_a[3]));

    // Reference: busy lasts for the first DEPTH edges after release; the
    // clear zeroes word N on edge N+1; afterwards requests follow the access rules.
    task automatic model_reset();
        m_edges = 0;
        for (int k = 0; k < 4; k++) begin
            m_dout[k] = '0; m_rv[k] = 1'b0; m_err[k] = 1'b0;
        end
    endtask

    task automatic model_edge();
        logic [15:0] old_w, new_w;
        for (int k = 0; k < 4; k++) begin
            if (m_edges < c_depth[k]) begin
                m_mem[k][m_edges] = '0;
                m_rv[k]  = 1'b0;
                m_err[k] = ce;
            end else if (!ce) begin
                m_rv[k] = 1'b0; m_err[k] = 1'b0;
            end else if (int'(addr) >= c_depth[k]) begin
                m_rv[k] = 1'b0; m_err[k] = 1'b1;
            end else begin
                m_err[k] = 1'b0;
                old_w = m_mem[k][addr];
                if (!we) begin
                    m_dout[k] = old_w; m_rv[k] = 1'b1;
                end else begin
                    new_w = old_w;
                    if (be[0]) new_w[7:0]  = din[7:0];
                    if (be[1]) new_w[15:8] = din[15:8];
                    m_mem[k][addr] = new_w;
                    if (c_mode[k] == 0) begin
                        m_dout[k] = old_w; m_rv[k] = 1'b1;
                    end else if (c_mode[k] == 1) begin
                        m_dout[k] = new_w; m_rv[k] = 1'b1;
                    end else begin
                        m_rv[k] = 1'b0;
                    end
                end
            end
        end
        m_edges++;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset(); else model_edge();
        #1;
    endtask

    task automatic drive(input logic c, input logic w, input logic [1:0] b,
                         input logic [7:0] a, input logic [15:0] d);
        ce = c; we = w; be = b; addr = a; din = d;
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1; model_reset(); drive(0, 0, 2'b00, 8'h00, 16'h0000);
        #1;
        for (int k = 0; k < 4; k++) begin
            total++;
            if ({dout_a[k], busy_a[k], rv_a[k], err_a[k]} !== {16'h0000, 1'b1, 1'b0, 1'b0}) begin
                bad++; $display("FAIL reset_state[%0d] got=%h/%b/%b/%b exp=0000/1/0/0", k, dout_a[k], busy_a[k], rv_a[k], err_a[k]);
            end
        end
        #19 rst = 1'b0;
        n = 0;
        while (busy_a[0] === 1'b1 && n < 400) begin
            tick(); n++;
            for (int k = 0; k < 4; k++) begin
                total++;
                if ({dout_a[k], rv_a[k], err_a[k], busy_a[k]} !== {m_dout[k], m_rv[k], m_err[k], (m_edges < c_depth[k])}) begin
                    bad++; $display("FAIL clear_cycle[%0d] n=%0d got=%h/%b/%b/%b exp=%h/%b/%b", k, n, dout_a[k], rv_a[k], err_a[k], busy_a[k], m_dout[k], m_rv[k], m_err[k]);
                end
            end
        end
        total++;
        if (n !== 256) begin bad++; $display("FAIL clear_length got=%0d exp=256", n); end
        foreach (c_depth[j]) begin end
        for (int r = 0; r < 3; r++) begin
            drive(1, 0, 2'b00, (r == 0) ? 8'h00 : (r == 1) ? 8'h7F : 8'hFF, 16'h0000);
            tick();
            total++;
            if ({dout_a[0], rv_a[0]} !== {16'h0000, 1'b1}) begin
                bad++; $display("FAIL clear_read a=%h got=%h/%b exp=0000/1", addr, dout_a[0], rv_a[0]);
            end
            for (int k = 0; k < 4; k++) begin
                total++;
                if ({dout_a[k], rv_a[k], err_a[k]} !== {m_dout[k], m_rv[k], m_err[k]}) begin
                    bad++; $display("FAIL clear_read_model[%0d] got=%h/%b/%b exp=%h/%b/%b", k, dout_a[k], rv_a[k], err_a[k], m_dout[k], m_rv[k], m_err[k]);
                end
            end
        end
        drive(0, 0, 2'b00, 8'h00, 16'h0000);
    endtask

    task automatic test_basic();
        drive(1, 1, 2'b11, 8'h01, 16'hAA55); tick();
        drive(1, 0, 2'b00, 8'h01, 16'h0000); tick();
        total++;
        if ({dout_a[0], rv_a[0]} !== {16'hAA55, 1'b1}) begin
            bad++; $display("FAIL basic_read got=%h/%b exp=aa55/1", dout_a[0], rv_a[0]);
        end
        drive(0, 0, 2'b00, 8'h00, 16'h0000); tick();
        for (int k = 0; k < 4; k++) begin
            total++;
            if ({dout_a[k], rv_a[k], err_a[k]} !== {m_dout[k], 1'b0, 1'b0}) begin
                bad++; $display("FAIL basic_pulse[%0d] got=%h/%b/%b exp=%h/0/0", k, dout_a[k], rv_a[k], err_a[k], m_dout[k]);
            end
        end
    endtask

    task automatic test_byte_en();
        drive(1, 1, 2'b11, 8'h10, 16'h1234); tick();
        drive(1, 1, 2'b01, 8'h10, 16'hFFFF); tick();
        drive(1, 0, 2'b00, 8'h10, 16'h0000); tick();
        total++;
        if (dout_a[0] !== 16'h12FF) begin bad++; $display("FAIL byte_en got=%h exp=12ff", dout_a[0]); end
        for (int k = 0; k < 4; k++) begin
            total++;
            if ({dout_a[k], rv_a[k]} !== {m_dout[k], m_rv[k]}) begin
                bad++; $display("FAIL byte_en_model[%0d] got=%h/%b exp=%h/%b", k, dout_a[k], rv_a[k], m_dout[k], m_rv[k]);
            end
        end
        drive(0, 0, 2'b00, 8'h00, 16'h0000);
    endtask

    task automatic test_rdw();
        logic [15:0] prev2;
        drive(1, 1, 2'b11, 8'h20, 16'h1111); tick();
        drive(0, 0, 2'b00, 8'h00, 16'h0000); tick();
        prev2 = m_dout[2];
        drive(1, 1, 2'b11, 8'h20, 16'h2222); tick();
        total++;
        if ({dout_a[0], rv_a[0]} !== {16'h1111, 1'b1}) begin bad++; $display("FAIL rdw_mode0 got=%h/%b exp=1111/1", dout_a[0], rv_a[0]); end
        total++;
        if ({dout_a[1], rv_a[1]} !== {16'h2222, 1'b1}) begin bad++; $display("FAIL rdw_mode1 got=%h/%b exp=2222/1", dout_a[1], rv_a[1]); end
        total++;
        if ({dout_a[2], rv_a[2]} !== {prev2, 1'b0}) begin bad++; $display("FAIL rdw_mode2 got=%h/%b exp=%h/0", dout_a[2], rv_a[2], prev2); end
        drive(1, 0, 2'b00, 8'h20, 16'h0000); tick();
        for (int k = 0; k < 4; k++) begin
            total++;
            if ({dout_a[k], rv_a[k]} !== {16'h2222, 1'b1}) begin
                bad++; $display("FAIL rdw_readback[%0d] got=%h/%b exp=2222/1", k, dout_a[k], rv_a[k]);
            end
        end
        drive(0, 0, 2'b00, 8'h00, 16'h0000);
    endtask

    task automatic test_reject();
        drive(1, 0, 2'b00, 8'h01, 16'h0000); tick();
        drive(1, 1, 2'b11, 8'hC8, 16'h5A5A); tick();
        drive(1, 0, 2'b00, 8'hC8, 16'h0000); tick();
        total++;
        if ({dout_a[3], rv_a[3], err_a[3]} !== {16'hAA55, 1'b0, 1'b1}) begin
            bad++; $display("FAIL reject_range got=%h/%b/%b exp=aa55/0/1", dout_a[3], rv_a[3], err_a[3]);
        end
        for (int k = 0; k < 4; k++) begin
            total++;
            if ({dout_a[k], rv_a[k], err_a[k]} !== {m_dout[k], m_rv[k], m_err[k]}) begin
                bad++; $display("FAIL reject_model[%0d] got=%h/%b/%b exp=%h/%b/%b", k, dout_a[k], rv_a[k], err_a[k], m_dout[k], m_rv[k], m_err[k]);
            end
        end
        drive(0, 0, 2'b00, 8'h00, 16'h0000); tick();
        total++;
        if (err_a[3] !== 1'b0) begin bad++; $display("FAIL reject_pulse got=%b exp=0", err_a[3]); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 64; i++) begin
            drive(1, (i < 32), 2'b11, 8'h40 + 8'(i % 32), 16'(i * 16'h0101 + 16'h0F00));
            tick();
            for (int k = 0; k < 4; k++) begin
                total++;
                if ({dout_a[k], rv_a[k], err_a[k]} !== {m_dout[k], m_rv[k], m_err[k]}) begin
                    bad++; $display("FAIL b2b[%0d] i=%0d got=%h/%b/%b exp=%h/%b/%b", k, i, dout_a[k], rv_a[k], err_a[k], m_dout[k], m_rv[k], m_err[k]);
                end
            end
        end
        drive(0, 0, 2'b00, 8'h00, 16'h0000);
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 9) != 0), $urandom_range(0, 1), 2'($urandom_range(0, 3)),
                  8'($urandom_range(0, 255)), 16'($urandom));
            tick();
            for (int k = 0; k < 4; k++) begin
                total++;
                if ({dout_a[k], rv_a[k], err_a[k], busy_a[k]} !== {m_dout[k], m_rv[k], m_err[k], 1'b0}) begin
                    bad++; $display("FAIL random[%0d] i=%0d got=%h/%b/%b/%b exp=%h/%b/%b/0", k, i, dout_a[k], rv_a[k], err_a[k], busy_a[k], m_dout[k], m_rv[k], m_err[k]);
                end
            end
        end
        drive(0, 0, 2'b00, 8'h00, 16'h0000);
    endtask

    task automatic test_reset_mid();
        int n;
        drive(1, 1, 2'b11, 8'h33, 16'hBEEF); tick();
        drive(1, 0, 2'b00, 8'h33, 16'h0000); tick();
        total++;
        if (dout_a[0] !== 16'hBEEF) begin bad++; $display("FAIL mid_pre got=%h exp=beef", dout_a[0]); end
        drive(0, 0, 2'b00, 8'h00, 16'h0000);
        rst = 1'b1; model_reset(); #1;
        for (int k = 0; k < 4; k++) begin
            total++;
            if ({dout_a[k], busy_a[k], rv_a[k]} !== {16'h0000, 1'b1, 1'b0}) begin
                bad++; $display("FAIL mid_op_rst[%0d] got=%h/%b/%b exp=0000/1/0", k, dout_a[k], busy_a[k], rv_a[k]);
            end
        end
        tick(); tick();
        #2 rst = 1'b0;
        for (int i = 0; i < 100; i++) tick();
        drive(1, 1, 2'b11, 8'h10, 16'hDEAD); tick();
        total++;
        if ({err_a[0], busy_a[0], rv_a[0]} !== 3'b110) begin
            bad++; $display("FAIL busy_write got=%b/%b/%b exp=1/1/0", err_a[0], busy_a[0], rv_a[0]);
        end
        drive(0, 0, 2'b00, 8'h00, 16'h0000);
        rst = 1'b1; model_reset(); #1;
        total++;
        if ({dout_a[0], busy_a[0], err_a[0]} !== {16'h0000, 1'b1, 1'b0}) begin
            bad++; $display("FAIL mid_clear_rst got=%h/%b/%b exp=0000/1/0", dout_a[0], busy_a[0], err_a[0]);
        end
        tick();
        #2 rst = 1'b0;
        n = 0;
        while (busy_a[0] === 1'b1 && n < 400) begin tick(); n++; end
        total++;
        if (n !== 256) begin bad++; $display("FAIL reclear_length got=%0d exp=256", n); end
        for (int r = 0; r < 3; r++) begin
            drive(1, 0, 2'b00, (r == 0) ? 8'h00 : (r == 1) ? 8'h10 : 8'h33, 16'h0000);
            tick();
            for (int k = 0; k < 4; k++) begin
                total++;
                if ({dout_a[k], rv_a[k], err_a[k]} !== {16'h0000, 1'b1, 1'b0}) begin
                    bad++; $display("FAIL reclear_read[%0d] a=%h got=%h/%b/%b exp=0000/1/0", k, addr, dout_a[k], rv_a[k], err_a[k]);
                end
            end
        end
        drive(0, 0, 2'b00, 8'h00, 16'h0000);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_byte_en();
        test_rdw();
        test_reject();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sp_ram_param.md
# sp_ram_param

Parametrised single-port synchronous RAM: successor to the fixed 8x256 bidirectional-bus RAM. Separate input/output data buses, per-byte write enables and a selectable read-during-write mode. A post-reset clear sequencer zeroes the whole array, and a registered read returns data with a valid strobe. It sits between a bus master or test bench and on-chip storage as a drop-in scratch memory.

## Interface
- DATA_W, 16, word width in bits; must be a multiple of BYTE_W.
- BYTE_W, 8, byte-lane width; NB = DATA_W/BYTE_W lanes.
- ADDR_W, 8, address width.
- DEPTH, 256, number of words; DEPTH <= 2**ADDR_W.
- RW_MODE, 0, read-during-write behaviour: 0 = read-first, 1 = write-first, 2 = no-change.
- CLEAR_ON_RST, 1, 1 = zero the array after reset; 0 = leave contents undefined and start idle.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- ce  in  1  chip enable; a request is accepted only when ce=1 and busy=0.
- we  in  1  1 = write, 0 = read; qualified by ce.
- be  in  NB  byte-lane write enables; bit i selects din[i*BYTE_W +: BYTE_W].
- addr  in  ADDR_W  word address.
- din  in  DATA_W  write data.
- dout  out  DATA_W  registered read data; holds its value between updates.
- rd_valid  out  1  one-cycle pulse: dout was updated on this edge.
- busy  out  1  high while the clear sequence runs.
- err  out  1  one-cycle pulse: a request was rejected.

## Operation
- FSM states: CLEAR and IDLE.
- On rst:
  - state = CLEAR if CLEAR_ON_RST=1, else IDLE.
  - clr_ptr = 0; dout = 0; rd_valid = 0; err = 0.
  - busy = 1 if CLEAR_ON_RST=1, else 0.
- CLEAR state:
  - Each cycle writes 0 to mem[clr_ptr] and increments clr_ptr.
  - On the edge that writes DEPTH-1, moves to IDLE and busy falls.
- IDLE state: on each edge with ce=1, addr < DEPTH and busy=0:
  - Read (we=0): dout = mem[addr]; rd_valid = 1.
  - Write (we=1): for each lane i with be[i]=1, mem[addr] lane i = din lane i; other lanes keep their value.
    - RW_MODE=0: dout = pre-write word; rd_valid = 1.
    - RW_MODE=1: dout = post-merge word; rd_valid = 1.
    - RW_MODE=2: dout unchanged; rd_valid = 0.
  - A write with be = 0 leaves memory unchanged. In modes 0 and 1 it still updates dout and pulses rd_valid.
- Rejected requests pulse err=1 for one cycle and do not change memory, dout or rd_valid. A request is rejected when ce=1 and either:
  - busy=1, or
  - addr >= DEPTH.
- ce=0: no memory access; rd_valid = 0; err = 0; dout holds.
- The write path and the clear path never both drive the array in the same cycle: while busy=1, user writes are blocked.

## Timing
- Read latency: 1 cycle. Request sampled at edge N; dout and rd_valid are valid after edge N and held until edge N+1.
- Back-to-back requests every cycle are accepted at full throughput with no bubbles.
- Clear duration: busy is high from reset assertion through exactly DEPTH rising edges after rst deasserts. The first request is accepted on edge DEPTH+1.
- rst asserted mid-clear: clr_ptr returns to 0 immediately and the clear restarts from address 0 after release.
- rst asserted mid-operation: outputs go to their reset values immediately. Memory contents are then re-cleared when CLEAR_ON_RST=1.
- rd_valid and err are never high in the same cycle.
- Address wrap: none. Addresses >= DEPTH are rejected, not aliased; this only applies when DEPTH < 2**ADDR_W.

## Test plan
- Reset/clear:
  - Stimulus: assert rst for 20 ns, release, then read addresses 0x00, 0x7F and 0xFF after busy falls.
  - Required: busy high for exactly 256 cycles; each read returns dout = 0x0000 with a rd_valid pulse.
- Basic write/read:
  - Stimulus: write 0xAA55 to address 0x01 with be = 2'b11, then read 0x01.
  - Required: dout = 0xAA55 one cycle after the read request; rd_valid is a single-cycle pulse.
- Byte enables:
  - Stimulus: write 0x1234 to 0x10, then write 0xFFFF with be = 2'b01, then read 0x10.
  - Required: dout = 0x12FF.
- Read-during-write modes:
  - Stimulus: address 0x20 holds 0x1111; write 0x2222 to it.
  - Required: same-cycle dout = 0x1111 in RW_MODE=0, 0x2222 in RW_MODE=1, and unchanged with rd_valid=0 in RW_MODE=2.
- Rejection:
  - Stimulus: issue a write during busy. Separately, with DEPTH = 200, read address 0xC8.
  - Required: err pulses once for each; memory and dout are unchanged; a later read of the targeted word returns its prior value.
- Reset mid-clear:
  - Stimulus: assert rst at clear cycle 100, release, then read address 0x00.
  - Required: busy stays high for 256 more cycles; dout = 0 immediately on rst; the read returns 0x0000.
